// File: rtl/imem_boot_ctrl.sv
// Boot/run controller: streams loader bytes into the instruction memory with the
// CPU stalled, then releases it and halts on out-of-range or misaligned fetches.
module imem_boot_ctrl #(
  parameter int MEM_BYTES = 36,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  input  logic [AW-1:0] PC,
  output logic          cpu_run,
  output logic          load_done,
  output logic          load_err,
  output logic          fetch_fault,
  output logic [AW-1:0] byte_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, ERR, HALT} state_t;

  localparam logic [AW-1:0] MEM_SIZE  = AW'(MEM_BYTES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_BYTES - 1);
  localparam logic [AW-1:0] FETCH_MAX = AW'(MEM_BYTES - 4);

  state_t        state;
  logic          accept;
  logic          fault;
  logic [AW-1:0] count_inc;

  // in_ready is a registered copy of (state == LOAD), so the write strobe is
  // a single AND away from a flop and drops to 0 asynchronously on reset.
  assign accept    = in_valid & in_ready;
  assign mem_we    = accept;
  assign mem_waddr = byte_count;
  assign mem_wdata = in_ready ? in_byte : 8'h00;
  assign count_inc = byte_count + AW'(1);
  assign fault     = (PC[1:0] != 2'b00) || (PC > FETCH_MAX);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      byte_count  <= '0;
      in_ready    <= 1'b0;
      cpu_run     <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (start && (state != LOAD)) begin
      // A start from any non-loading state restarts cleanly and drops any
      // byte offered in the same cycle, since in_ready is still low.
      state       <= LOAD;
      byte_count  <= '0;
      in_ready    <= 1'b1;
      cpu_run     <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (byte_count != MEM_SIZE) begin
              byte_count <= count_inc;
            end
            if (in_last) begin
              in_ready <= 1'b0;
              if (count_inc[1:0] == 2'b00) begin
                state     <= RUN;
                cpu_run   <= 1'b1;
                load_done <= 1'b1;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end else if (byte_count == LAST_ADDR) begin
              // Memory full: the load ends without an explicit last byte.
              state     <= RUN;
              in_ready  <= 1'b0;
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fault) begin
            state       <= HALT;
            cpu_run     <= 1'b0;
            fetch_fault <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed and randomized loads and fetch sequences
// checked against a behavioural model of the load/fetch rules.
module tb_imem_boot_ctrl;

  localparam int MEM_BYTES = 36;
  localparam int AW        = 32;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] PC = '0;
  logic          cpu_run;
  logic          load_done;
  logic          load_err;
  logic          fetch_fault;
  logic [AW-1:0] byte_count;

  int n_cmp = 0;
  int n_fail = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  int            n_offer;
  bit            timed_out;

  imem_boot_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
    .clk(clk), .Reset(Reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .PC(PC), .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err),
    .fetch_fault(fetch_fault), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules: with in_last on byte N (N <= memory size) the load ends
  // after N bytes and is good iff N is a multiple of 4; otherwise the memory
  // fills and the load ends good after MEM_BYTES bytes.
  task automatic model_load(input int len, input bit use_last, output int n_acc, output bit ok);
    if (use_last && len <= MEM_BYTES) begin
      n_acc = len;
      ok    = (len % 4) == 0;
    end else begin
      n_acc = (len < MEM_BYTES) ? len : MEM_BYTES;
      ok    = 1'b1;
    end
  endtask

  function automatic bit model_fault(input logic [AW-1:0] pc);
    return (pc % 4 != 0) || (pc > MEM_BYTES - 4);
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers bytes in order, optionally gating in_valid, and records every write
  // strobe seen. Returns at the negedge before the final accepting edge.
  task automatic drive_load(input bq_t data, input bit use_last, input int idle_pct, input int budget);
    int idx = 0;
    int cyc = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    n_offer = 0;
    while (idx < data.size() && cyc < budget) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(99) >= idle_pct);
      in_byte  = data[idx];
      in_last  = use_last && (idx == data.size() - 1);
      @(negedge clk);
      if (in_valid) n_offer++;
      if (mem_we) begin
        wr_addr_q.push_back(mem_waddr);
        wr_data_q.push_back(mem_wdata);
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    timed_out = (idx < data.size());
  endtask

  task automatic finish_load();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_byte = 8'hAA;
    #2;
    n_cmp++; if ({in_ready, mem_we, cpu_run, load_done, load_err, fetch_fault} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {in_ready, mem_we, cpu_run, load_done, load_err, fetch_fault}); end
    n_cmp++; if (mem_waddr !== '0 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_port: got addr %0h data %0h want 0 0", mem_waddr, mem_wdata); end
    n_cmp++; if (byte_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", byte_count); end
    @(negedge clk); Reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || cpu_run !== 1'b0) begin n_fail++; $display("FAIL idle_outputs: got ready %b run %b want 0 0", in_ready, cpu_run); end
  endtask

  task automatic test_basic_load();
    bq_t d = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20};
    pulse_start();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    drive_load(d, 1'b1, 0, 40);
    n_cmp++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL basic_run_early: got %b want 0", cpu_run); end
    finish_load();
    n_cmp++; if (wr_addr_q.size() !== 8) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 8", wr_addr_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
      n_cmp++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== d[i]) begin n_fail++; $display("FAIL basic_write[%0d]: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, d[i]); end
    end
    n_cmp++; if (cpu_run !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0) begin n_fail++; $display("FAIL basic_run: got run %b done %b err %b want 1 1 0", cpu_run, load_done, load_err); end
    n_cmp++; if (byte_count !== 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", byte_count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b want 0", in_ready); end
  endtask

  task automatic test_err_recover();
    pulse_start();
    drive_load(rand_bytes(6), 1'b1, 0, 40);
    finish_load();
    repeat (2) @(negedge clk);
    n_cmp++; if (load_err !== 1'b1 || cpu_run !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL err_state: got err %b run %b done %b want 1 0 0", load_err, cpu_run, load_done); end
    n_cmp++; if (byte_count !== 6 || wr_addr_q.size() !== 6) begin n_fail++; $display("FAIL err_count: got %0d/%0d want 6/6", byte_count, wr_addr_q.size()); end
    pulse_start();
    n_cmp++; if (load_err !== 1'b0 || byte_count !== 0) begin n_fail++; $display("FAIL err_clear: got err %b count %0d want 0 0", load_err, byte_count); end
    drive_load(rand_bytes(4), 1'b1, 0, 40);
    finish_load();
    n_cmp++; if (cpu_run !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0) begin n_fail++; $display("FAIL err_recover_run: got run %b done %b err %b want 1 1 0", cpu_run, load_done, load_err); end
  endtask

  task automatic test_overflow();
    bq_t d = rand_bytes(40);
    pulse_start();
    drive_load(d, 1'b0, 0, 50);
    finish_load();
    n_cmp++; if (wr_addr_q.size() !== MEM_BYTES) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want %0d", wr_addr_q.size(), MEM_BYTES); end
    for (int i = 0; i < wr_addr_q.size() && i < MEM_BYTES; i++) begin
      n_cmp++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== d[i]) begin n_fail++; $display("FAIL ovf_write[%0d]: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, d[i]); end
    end
    n_cmp++; if (in_ready !== 1'b0 || cpu_run !== 1'b1 || byte_count !== MEM_BYTES) begin n_fail++; $display("FAIL ovf_end: got ready %b run %b count %0d want 0 1 %0d", in_ready, cpu_run, byte_count, MEM_BYTES); end
  endtask

  task automatic test_fetch_range();
    for (int p = 0; p <= MEM_BYTES; p += 4) begin
      @(negedge clk); PC = AW'(p);
      @(posedge clk); #1;
      n_cmp++; if (fetch_fault !== model_fault(AW'(p)) || cpu_run !== !model_fault(AW'(p))) begin n_fail++; $display("FAIL fetch_pc%0d: got fault %b run %b want %b %b", p, fetch_fault, cpu_run, model_fault(AW'(p)), !model_fault(AW'(p))); end
    end
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b want 1", load_done); end
    @(negedge clk); PC = '0;
    @(posedge clk); #1;
    n_cmp++; if (fetch_fault !== 1'b1 || cpu_run !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got fault %b run %b want 1 0", fetch_fault, cpu_run); end
  endtask

  task automatic test_restart();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_byte = 8'h5A; in_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL restart_no_write: got %b want 0", mem_we); end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || byte_count !== 0 || cpu_run !== 1'b0 || fetch_fault !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL restart_state: got ready %b count %0d run %b fault %b done %b want 1 0 0 0 0", in_ready, byte_count, cpu_run, fetch_fault, load_done); end
    drive_load(rand_bytes(2), 1'b0, 0, 10);
    finish_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || byte_count !== 2) begin n_fail++; $display("FAIL start_in_load: got ready %b count %0d want 1 2", in_ready, byte_count); end
    drive_load(rand_bytes(2), 1'b1, 0, 10);
    finish_load();
    n_cmp++; if (cpu_run !== 1'b1 || byte_count !== 4) begin n_fail++; $display("FAIL restart_run: got run %b count %0d want 1 4", cpu_run, byte_count); end
  endtask

  task automatic test_fetch_misalign();
    logic [AW-1:0] p;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); PC = AW'(4 * $urandom_range(MEM_BYTES / 4 - 1));
      @(posedge clk); #1;
      n_cmp++; if (cpu_run !== 1'b1 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fetch_ok[%0d]: got run %b fault %b want 1 0", i, cpu_run, fetch_fault); end
    end
    @(negedge clk); PC = 32'd6;
    @(posedge clk); #1;
    n_cmp++; if (fetch_fault !== 1'b1 || cpu_run !== 1'b0) begin n_fail++; $display("FAIL fetch_pc6: got fault %b run %b want 1 0", fetch_fault, cpu_run); end
    @(negedge clk); PC = '0;
    pulse_start();
    drive_load(rand_bytes(4), 1'b1, 0, 10);
    finish_load();
    p = 32'hFFFF_FFFC;
    @(negedge clk); PC = p;
    @(posedge clk); #1;
    n_cmp++; if (fetch_fault !== model_fault(p) || cpu_run !== 1'b0) begin n_fail++; $display("FAIL fetch_high: got fault %b run %b want 1 0", fetch_fault, cpu_run); end
    @(negedge clk); PC = '0;
  endtask

  task automatic test_gated();
    bq_t d = rand_bytes(12);
    pulse_start();
    drive_load(d, 1'b1, 67, 400);
    finish_load();
    n_cmp++; if (timed_out || wr_addr_q.size() !== 12 || n_offer !== 12) begin n_fail++; $display("FAIL gated_nwrites: got writes %0d offers %0d timeout %b want 12 12 0", wr_addr_q.size(), n_offer, timed_out); end
    for (int i = 0; i < wr_addr_q.size() && i < 12; i++) begin
      n_cmp++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== d[i]) begin n_fail++; $display("FAIL gated_write[%0d]: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, d[i]); end
    end
    n_cmp++; if (cpu_run !== 1'b1 || byte_count !== 12) begin n_fail++; $display("FAIL gated_end: got run %b count %0d want 1 12", cpu_run, byte_count); end
  endtask

  task automatic test_random_loads();
    int len, n_acc, idle;
    bit use_last, ok;
    bq_t d;
    for (int k = 0; k < 8; k++) begin
      use_last = 1'($urandom_range(1));
      len  = use_last ? int'($urandom_range(1, 40)) : int'($urandom_range(MEM_BYTES, 40));
      idle = $urandom_range(0, 50);
      d = rand_bytes(len);
      model_load(len, use_last, n_acc, ok);
      pulse_start();
      drive_load(d, use_last, idle, 400);
      finish_load();
      n_cmp++; if (wr_addr_q.size() !== n_acc || byte_count !== n_acc) begin n_fail++; $display("FAIL rand%0d_count: got writes %0d count %0d want %0d", k, wr_addr_q.size(), byte_count, n_acc); end
      for (int i = 0; i < wr_addr_q.size() && i < n_acc; i++) begin
        n_cmp++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== d[i]) begin n_fail++; $display("FAIL rand%0d_write[%0d]: got %0h/%0h want %0h/%0h", k, i, wr_addr_q[i], wr_data_q[i], i, d[i]); end
      end
      n_cmp++; if (cpu_run !== ok || load_done !== ok || load_err !== !ok) begin n_fail++; $display("FAIL rand%0d_end(len %0d last %b): got run %b done %b err %b want %b %b %b", k, len, use_last, cpu_run, load_done, load_err, ok, ok, !ok); end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    drive_load(rand_bytes(5), 1'b0, 0, 10);
    @(posedge clk); #1;
    n_cmp++; if (byte_count !== 5 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midload_count: got %0d ready %b want 5 1", byte_count, in_ready); end
    #2 Reset = 1'b0;
    #1;
    n_cmp++; if ({in_ready, mem_we, cpu_run, load_done, load_err, fetch_fault} !== 6'b0) begin n_fail++; $display("FAIL midload_async_flags: got %b want 000000", {in_ready, mem_we, cpu_run, load_done, load_err, fetch_fault}); end
    n_cmp++; if (mem_waddr !== '0 || mem_wdata !== 8'h00 || byte_count !== '0) begin n_fail++; $display("FAIL midload_async_port: got addr %0h data %0h count %0d want 0 0 0", mem_waddr, mem_wdata, byte_count); end
    @(negedge clk); Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || byte_count !== '0) begin n_fail++; $display("FAIL idle_ignores_valid[%0d]: got we %b ready %b count %0d want 0 0 0", i, mem_we, in_ready, byte_count); end
    end
    pulse_start();
    drive_load(rand_bytes(4), 1'b1, 0, 10);
    finish_load();
    n_cmp++; if (cpu_run !== 1'b1 || byte_count !== 4) begin n_fail++; $display("FAIL postreset_load: got run %b count %0d want 1 4", cpu_run, byte_count); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_err_recover();
    test_overflow();
    test_fetch_range();
    test_restart();
    test_fetch_misalign();
    test_gated();
    test_random_loads();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
